rom_sequencer: RTL
==================

// Module: rom_sequencer
// PURPOSE
//  Program store and program counter feeding the 4-bit CPU controller in run mode.
//  - Holds an IW-bit instruction memory, written by the user-side loader.
//  - Presents rom_inst at the current PC and advances on each controller inst_done pulse.
//  - Raises rom_done once the programmed number of instructions has executed.
// PARAMETERS
//  IW     8    instruction width (opcode[7:6], Rx[5:4], Ry[3:2], funct/data[3:0])
//  AW     4    address width
//  DEPTH  16   memory words, fixed at 2**AW
// PORTS
//  clk          in   1     system clock, all logic on posedge
//  clr_n        in   1     synchronous, active-low reset
//  prog_we      in   1     write prog_data to mem[prog_addr]
//  prog_addr    in   AW    program write address
//  prog_data    in   IW    program write data
//  len_we       in   1     write prog_len to the length register
//  prog_len     in   AW+1  instruction count, 0..DEPTH
//  start        in   1     single-cycle pulse: begin or restart run at PC 0
//  inst_done    in   1     controller pulse: current instruction finished
//  rom_inst     out  IW    registered instruction, mem[pc]
//  rom_done     out  1     program complete (high in DONE state)
//  pc           out  AW    current program counter
//  busy         out  1     high in RUN state
//  wr_err       out  1     sticky: write attempted while busy
// BEHAVIOUR
//  Reset (clr_n=0 at posedge):
//   - state=IDLE; pc=0, len=0, rom_inst=0, rom_done=0, busy=0, wr_err=0.
//   - Memory contents are NOT cleared.
//   - Takes effect from any state, including mid-RUN; all other inputs ignored that cycle.
//  rom_inst:
//   - Updated every cycle as rom_inst <= mem[pc].
//   - Valid one cycle after pc changes. inst_done(N) -> pc valid N+1 -> rom_inst valid N+2.
//   - This matches the controller fetch->exec spacing.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - prog_we writes mem; len_we writes len, saturated to DEPTH if prog_len>DEPTH.
//   - start: pc<=0; next state RUN if len!=0, else DONE.
//   - inst_done is ignored.
//  RUN:
//   - busy=1.
//   - inst_done while pc+1<len: pc<=pc+1.
//   - inst_done while pc+1==len: pc holds, state<=DONE. pc never wraps.
//   - start: pc<=0 (restart); state stays RUN, or goes DONE if len==0.
//   - start and inst_done together: start wins, inst_done is dropped.
//   - prog_we/len_we are ignored (mem/len unchanged) and set wr_err.
//  DONE:
//   - rom_done=1. The controller samples it in run_fetch or at the last inst_done state.
//   - Writes are accepted as in IDLE.
//   - start: behaves as from IDLE.
//   - inst_done is ignored.
//   - Stays in DONE until start or reset.
//  Simultaneous events:
//   - In IDLE/DONE, start with len_we: start uses the OLD len; the new len is stored.
//   - Same-cycle prog_we to mem[pc] in IDLE/DONE: visible on rom_inst two cycles later.
//  Other rules:
//   - wr_err is cleared only by reset or start.
//   - All pc arithmetic is AW+1 bits wide for the pc+1==len compare.
// TESTING
//  1 Reset: clr_n=0 one cycle -> pc=0, rom_done=0, busy=0, wr_err=0, rom_inst=8'h00.
//  2 Normal run:
//    - Load mem[0..2]=8'h05,8'h42,8'hC1, len=3, start.
//    - Pulse inst_done x3 (spaced 3 cycles) -> rom_inst 05,42,C1.
//    - rom_done=1 the cycle after the 3rd pulse; pc holds 2.
//  3 Empty program: len=0, start -> rom_done=1 next cycle, busy=0; inst_done ignored.
//  4 Write while busy: in RUN, prog_we addr 1 data 8'hFF -> mem[1] unchanged, wr_err=1.
//    Next start -> wr_err=0.
//  5 Collisions:
//    - start and inst_done together at pc=2 -> pc=0, state RUN.
//    - len_we with prog_len=20 -> len saturates to 16.
//    - Full-depth run of 16 ends with pc=15, rom_done=1, no wrap.
//  6 Reset mid-run: clr_n=0 at pc=1 -> IDLE, pc=0, rom_done=0.
//    Memory retained: start with len=3 re-executes 05,42,C1.

Source files
------------

// File: rtl/rom_sequencer.sv
// Program store plus program counter for the 4-bit CPU controller's run mode.
// The user-side loader fills the memory and length; start/inst_done step the PC through the program.
module rom_sequencer #(
    parameter int IW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          len_we,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          inst_done,
    output logic [IW-1:0] rom_inst,
    output logic          rom_done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          wr_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   len;
    logic [AW:0]   pc_inc;
    logic [AW:0]   len_sat;

    // Widened by one bit so that pc+1 can equal len when len == DEPTH.
    assign pc_inc  = {1'b0, pc} + 1'b1;
    assign len_sat = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

    // The memory has no reset: a program survives clr_n.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= IDLE;
            pc       <= '0;
            len      <= '0;
            rom_inst <= '0;
            rom_done <= 1'b0;
            busy     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rom_inst <= mem[pc];
            case (state)
                IDLE, DONE: begin
                    if (prog_we) mem[prog_addr] <= prog_data;
                    if (len_we) len <= len_sat;
                    // start looks at the old len even when len_we fires in the same cycle.
                    if (start) begin
                        pc     <= '0;
                        wr_err <= 1'b0;
                        if (len != '0) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            rom_done <= 1'b0;
                        end else begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            rom_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (start) begin
                        pc     <= '0;
                        wr_err <= 1'b0;
                        if (len == '0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            rom_done <= 1'b1;
                        end
                    end else if (inst_done) begin
                        if (pc_inc < len) begin
                            pc <= pc + 1'b1;
                        end else begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            rom_done <= 1'b1;
                        end
                    end
                    if (prog_we || len_we) wr_err <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rom_done <= 1'b0;
                end
            endcase
        end
    end
endmodule
